// File: rtl/button_conditioner.sv
// Two-channel push-button front end: synchronises the active-low pins, debounces each
// channel with its own FSM and produces registered request levels, press/release pulses and a tie flag.
module button_conditioner #(
    parameter int CLOCK_FREQ     = 1000,
    parameter int DEBOUNCE_MS    = 20,
    parameter int DEBOUNCE_COUNT = CLOCK_FREQ * DEBOUNCE_MS / 1000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn1_in_n,
    input  logic btn2_in_n,
    output logic req1_out,
    output logic req2_out,
    output logic press1_out,
    output logic press2_out,
    output logic release1_out,
    output logic release2_out,
    output logic tie_out
);

    localparam int CNT_W = $clog2(DEBOUNCE_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    logic [1:0]             pin_n_s;
    logic [SYNC_STAGES-1:0] sync_r [2];
    logic [1:0]             pressed_s;
    state_t                 state_r [2];
    state_t                 state_nxt_s [2];
    logic [CNT_W-1:0]       cnt_r [2];
    logic [CNT_W-1:0]       cnt_nxt_s [2];
    logic [1:0]             req_nxt_s;
    logic [1:0]             press_nxt_s;
    logic [1:0]             release_nxt_s;
    logic                   tie_nxt_s;
    logic [1:0]             req_r;
    logic [1:0]             press_r;
    logic [1:0]             release_r;
    logic                   tie_r;

    assign pin_n_s = {btn2_in_n, btn1_in_n};

    // Synchroniser chains; reset loads the released (high) level.
    always_ff @(posedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (reset) begin
                sync_r[ch] <= {SYNC_STAGES{1'b1}};
            end else begin
                sync_r[ch] <= {sync_r[ch][SYNC_STAGES-2:0], pin_n_s[ch]};
            end
        end
    end

    // Active-high synchronised button level per channel.
    always_comb begin
        pressed_s = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            pressed_s[ch] = ~sync_r[ch][SYNC_STAGES-1];
        end
    end

    // Debounce FSM state and counter registers.
    always_ff @(posedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (reset) begin
                state_r[ch] <= ST_IDLE;
                cnt_r[ch]   <= CNT_ZERO;
            end else begin
                state_r[ch] <= state_nxt_s[ch];
                cnt_r[ch]   <= cnt_nxt_s[ch];
            end
        end
    end

    // Next-state logic; the counter tops out at DEBOUNCE_COUNT-1 and never wraps.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state_nxt_s[ch] = state_r[ch];
            cnt_nxt_s[ch]   = cnt_r[ch];
            case (state_r[ch])
                ST_IDLE: begin
                    if (pressed_s[ch]) begin
                        state_nxt_s[ch] = ST_PRESS_WAIT;
                        cnt_nxt_s[ch]   = CNT_ONE;
                    end else begin
                        cnt_nxt_s[ch]   = CNT_ZERO;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!pressed_s[ch]) begin
                        state_nxt_s[ch] = ST_IDLE;
                        cnt_nxt_s[ch]   = CNT_ZERO;
                    end else if (cnt_r[ch] == CNT_LAST) begin
                        state_nxt_s[ch] = ST_PRESSED;
                        cnt_nxt_s[ch]   = CNT_ZERO;
                    end else begin
                        cnt_nxt_s[ch]   = cnt_r[ch] + CNT_ONE;
                    end
                end
                ST_PRESSED: begin
                    if (!pressed_s[ch]) begin
                        state_nxt_s[ch] = ST_RELEASE_WAIT;
                        cnt_nxt_s[ch]   = CNT_ONE;
                    end else begin
                        cnt_nxt_s[ch]   = CNT_ZERO;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (pressed_s[ch]) begin
                        state_nxt_s[ch] = ST_PRESSED;
                        cnt_nxt_s[ch]   = CNT_ZERO;
                    end else if (cnt_r[ch] == CNT_LAST) begin
                        state_nxt_s[ch] = ST_IDLE;
                        cnt_nxt_s[ch]   = CNT_ZERO;
                    end else begin
                        cnt_nxt_s[ch]   = cnt_r[ch] + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt_s[ch] = ST_IDLE;
                    cnt_nxt_s[ch]   = CNT_ZERO;
                end
            endcase
        end
    end

    // Output terms derived from the transition about to be taken.
    always_comb begin
        req_nxt_s     = 2'b00;
        press_nxt_s   = 2'b00;
        release_nxt_s = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            case (state_nxt_s[ch])
                ST_PRESSED, ST_RELEASE_WAIT: req_nxt_s[ch] = 1'b1;
                default:                     req_nxt_s[ch] = 1'b0;
            endcase
            press_nxt_s[ch]   = (state_r[ch] == ST_PRESS_WAIT) && (state_nxt_s[ch] == ST_PRESSED);
            release_nxt_s[ch] = (state_r[ch] == ST_RELEASE_WAIT) && (state_nxt_s[ch] == ST_IDLE);
        end
        tie_nxt_s = press_nxt_s[0] & press_nxt_s[1];
    end

    // Registered outputs so nothing downstream sees a combinational path from the pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_r     <= 2'b00;
            press_r   <= 2'b00;
            release_r <= 2'b00;
            tie_r     <= 1'b0;
        end else begin
            req_r     <= req_nxt_s;
            press_r   <= press_nxt_s;
            release_r <= release_nxt_s;
            tie_r     <= tie_nxt_s;
        end
    end

    assign req1_out     = req_r[0];
    assign req2_out     = req_r[1];
    assign press1_out   = press_r[0];
    assign press2_out   = press_r[1];
    assign release1_out = release_r[0];
    assign release2_out = release_r[1];
    assign tie_out      = tie_r;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: a run-length model of the debounce rules checked every cycle,
// plus hand-computed latency and pulse-count expectations for directed scenarios.
module tb_button_conditioner;

    localparam int SYNC = 2;
    localparam int DC   = 20;

    logic clk = 1'b0;
    logic reset;
    logic btn1_in_n;
    logic btn2_in_n;
    logic req1_out, req2_out, press1_out, press2_out;
    logic release1_out, release2_out, tie_out;

    int n_cmp = 0;
    int n_err = 0;

    // model state: pin-sample delay line, debounced level, run of disagreeing samples
    int m_hist [2][$];
    int m_lvl  [2];
    int m_run  [2];
    int m_press [2];
    int m_rel  [2];
    int m_tie;

    // per-scenario statistics
    int edge_ctr, rise1_at, fall1_at, rise2_at;
    int press1_cnt, press2_cnt, rel1_cnt, rel2_cnt, tie_cnt, req1_low_cnt, req1_high_cnt;
    logic prev_req1, prev_req2;

    button_conditioner #(
        .CLOCK_FREQ(1000), .DEBOUNCE_MS(20), .DEBOUNCE_COUNT(DC), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .reset(reset), .btn1_in_n(btn1_in_n), .btn2_in_n(btn2_in_n),
        .req1_out(req1_out), .req2_out(req2_out),
        .press1_out(press1_out), .press2_out(press2_out),
        .release1_out(release1_out), .release2_out(release2_out),
        .tie_out(tie_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic p1, input logic p2);
        int s;
        int pin [2];
        pin[0] = (p1 === 1'b1) ? 1 : 0;
        pin[1] = (p2 === 1'b1) ? 1 : 0;
        m_tie = 0;
        for (int ch = 0; ch < 2; ch++) begin
            m_press[ch] = 0;
            m_rel[ch]   = 0;
            if (r) begin
                m_hist[ch].delete();
                for (int k = 0; k < SYNC; k++) m_hist[ch].push_back(1);
                m_lvl[ch] = 0;
                m_run[ch] = 0;
            end else begin
                // the debouncer sees the pin as it was SYNC edges earlier
                s = (m_hist[ch].pop_front() == 0) ? 1 : 0;
                m_hist[ch].push_back(pin[ch]);
                m_run[ch] = (s != m_lvl[ch]) ? m_run[ch] + 1 : 0;
                if (m_run[ch] == DC) begin
                    m_lvl[ch] = s;
                    m_run[ch] = 0;
                    if (s == 1) m_press[ch] = 1;
                    else        m_rel[ch]   = 1;
                end
            end
        end
        if (!r) m_tie = m_press[0] & m_press[1];
    endtask

    task automatic mark();
        edge_ctr = 0;
        rise1_at = -1; fall1_at = -1; rise2_at = -1;
        press1_cnt = 0; press2_cnt = 0; rel1_cnt = 0; rel2_cnt = 0; tie_cnt = 0;
        req1_low_cnt = 0; req1_high_cnt = 0;
        prev_req1 = req1_out; prev_req2 = req2_out;
    endtask

    // one clock: model advances on the edge, every output is compared half a cycle later
    task automatic tick();
        logic r, p1, p2;
        r = reset; p1 = btn1_in_n; p2 = btn2_in_n;
        @(posedge clk);
        model_step(r, p1, p2);
        edge_ctr++;
        @(negedge clk);
        check("req1",     int'(req1_out),     m_lvl[0]);
        check("req2",     int'(req2_out),     m_lvl[1]);
        check("press1",   int'(press1_out),   m_press[0]);
        check("press2",   int'(press2_out),   m_press[1]);
        check("release1", int'(release1_out), m_rel[0]);
        check("release2", int'(release2_out), m_rel[1]);
        check("tie",      int'(tie_out),      m_tie);
        if (req1_out === 1'b1 && prev_req1 !== 1'b1 && rise1_at < 0) rise1_at = edge_ctr;
        if (req1_out === 1'b0 && prev_req1 === 1'b1 && fall1_at < 0) fall1_at = edge_ctr;
        if (req2_out === 1'b1 && prev_req2 !== 1'b1 && rise2_at < 0) rise2_at = edge_ctr;
        if (press1_out === 1'b1)   press1_cnt++;
        if (press2_out === 1'b1)   press2_cnt++;
        if (release1_out === 1'b1) rel1_cnt++;
        if (release2_out === 1'b1) rel2_cnt++;
        if (tie_out === 1'b1)      tie_cnt++;
        if (req1_out === 1'b0)     req1_low_cnt++;
        if (req1_out === 1'b1)     req1_high_cnt++;
        prev_req1 = req1_out;
        prev_req2 = req2_out;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive1(input logic v, input int n);
        btn1_in_n = v;
        run(n);
    endtask

    initial begin
        reset = 1'b1; btn1_in_n = 1'b0; btn2_in_n = 1'b0;
        // 1: reset held with both buttons down
        mark();
        run(3);
        check("reset_req1_high", req1_high_cnt, 0);
        check("reset_pulses", press1_cnt + press2_cnt + rel1_cnt + tie_cnt, 0);
        reset = 1'b0; btn1_in_n = 1'b1; btn2_in_n = 1'b1;
        run(5);

        // 2: clean press on channel 1, then clean release
        mark();
        drive1(1'b0, 40);
        check("t2_rise_edge", rise1_at, 22);
        check("t2_press1_cnt", press1_cnt, 1);
        check("t2_other_pulses", rel1_cnt + press2_cnt + tie_cnt + rel2_cnt, 0);
        mark();
        drive1(1'b1, 30);
        check("t2_fall_edge", fall1_at, 22);
        check("t2_release1_cnt", rel1_cnt, 1);

        // 3: bounce before the final low
        mark();
        drive1(1'b0, 5); drive1(1'b1, 2); drive1(1'b0, 5); drive1(1'b1, 1);
        check("t3_no_req_in_bounce", req1_high_cnt, 0);
        mark();
        drive1(1'b0, 30);
        check("t3_rise_edge", rise1_at, 22);
        check("t3_press1_cnt", press1_cnt, 1);
        drive1(1'b1, 30);

        // 4: both buttons together -> tie
        mark();
        btn1_in_n = 1'b0; btn2_in_n = 1'b0;
        run(30);
        check("t4_rise1_edge", rise1_at, 22);
        check("t4_rise2_edge", rise2_at, 22);
        check("t4_tie_cnt", tie_cnt, 1);
        check("t4_press_cnt", press1_cnt + press2_cnt, 2);
        btn1_in_n = 1'b1; btn2_in_n = 1'b1;
        run(30);

        // 5: release glitch while pressed
        drive1(1'b0, 30);
        mark();
        drive1(1'b1, 3); drive1(1'b0, 2);
        mark();
        drive1(1'b1, 30);
        check("t5_fall_edge", fall1_at, 22);
        check("t5_release1_cnt", rel1_cnt, 1);
        check("t5_req_held_before_fall", req1_low_cnt, 30 - 21);

        // 6: reset mid press-wait, then mid pressed, button held down
        mark();
        drive1(1'b0, 12);
        check("t6_no_req_yet", req1_high_cnt, 0);
        reset = 1'b1;
        mark();
        run(1);
        reset = 1'b0;
        mark();
        run(30);
        check("t6_rise_after_reset_a", rise1_at, 22);
        check("t6_press_cnt_a", press1_cnt, 1);
        reset = 1'b1;
        mark();
        run(1);
        check("t6_req_cleared", int'(req1_out), 0);
        check("t6_no_release", rel1_cnt, 0);
        reset = 1'b0;
        mark();
        run(30);
        check("t6_rise_after_reset_b", rise1_at, 22);
        check("t6_press_cnt_b", press1_cnt, 1);
        check("t6_no_release_b", rel1_cnt, 0);
        drive1(1'b1, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
